// File: rtl/key_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_game_pkg
// Purpose  : Shared encodings for the key command scheduler: game states,
//            command codes and the scheduler FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package key_game_pkg;

  // Game state as driven by the game core
  localparam logic [1:0] c_GS_IDLE    = 2'b00;
  localparam logic [1:0] c_GS_PLAYING = 2'b01;
  localparam logic [1:0] c_GS_PAUSED  = 2'b10;
  localparam logic [1:0] c_GS_OVER    = 2'b11;

  // Commands offered to the game core
  localparam logic [1:0] c_CMD_GRAVITY = 2'b00;
  localparam logic [1:0] c_CMD_LEFT    = 2'b01;
  localparam logic [1:0] c_CMD_RIGHT   = 2'b10;
  localparam logic [1:0] c_CMD_DOWN    = 2'b11;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_STEP = 2'd1,
    ST_ISSUE     = 2'd2
  } sched_state_t;

  // IDLE and OVER both stop the game and flush all scheduler state
  function automatic logic gs_is_stopped(input logic [1:0] gs);
    return (gs == c_GS_IDLE) || (gs == c_GS_OVER);
  endfunction

endpackage : key_game_pkg
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Small synchronous command queue with registered read pointer,
//            flush, and simultaneous push/pop support when full.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push
  // when it is popped at the same time.
  assign o_full    = (r_count == LW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_level   = r_count;

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok && !rst && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : key_cmd_scheduler
// Purpose  : Queues arbitrated key presses and offers one command (queued key
//            or GRAVITY) to the game core on every game step.
// Revision : 1.0 - initial release
// ============================================================================
module key_cmd_scheduler
  import key_game_pkg::*;
#(
  parameter int STEP_DIV   = 5000000,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1,
  localparam int CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1
) (
  input  logic          CLK_50M,
  input  logic          RST,
  input  logic [1:0]    game_state,
  input  logic          left_key_press,
  input  logic          right_key_press,
  input  logic          down_key_press,
  output logic          cmd_valid,
  output logic [1:0]    cmd_code,
  input  logic          cmd_ready,
  output logic [LW-1:0] queue_level,
  output logic          overflow
);

  sched_state_t  r_state;
  sched_state_t  w_state_nx;
  logic [1:0]    r_code;
  logic [1:0]    w_code_nx;
  logic [CW-1:0] r_cnt;
  logic          r_step_pending;
  logic          r_overflow;

  logic          w_playing;
  logic          w_stop;
  logic          w_tc;
  logic          w_step;
  logic          w_take_step;
  logic          w_key_valid;
  logic [1:0]    w_key_code;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head;
  logic          w_full;
  logic          w_empty;

  assign w_playing = (game_state == c_GS_PLAYING);
  assign w_stop    = gs_is_stopped(game_state);
  assign w_tc      = w_playing && (r_cnt == CW'(STEP_DIV - 1));
  // The terminal count itself is usable in the same cycle, giving a one-cycle
  // path from terminal count to cmd_valid.
  assign w_step    = r_step_pending || w_tc;

  // Fixed-priority key arbitration: DOWN > LEFT > RIGHT
  always_comb begin
    w_key_valid = 1'b1;
    w_key_code  = c_CMD_GRAVITY;
    if (down_key_press) begin
      w_key_code = c_CMD_DOWN;
    end else if (left_key_press) begin
      w_key_code = c_CMD_LEFT;
    end else if (right_key_press) begin
      w_key_code = c_CMD_RIGHT;
    end else begin
      w_key_valid = 1'b0;
    end
  end

  assign w_push = w_playing && w_key_valid;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_cmd_fifo (
    .clk     (CLK_50M),
    .rst     (RST),
    .i_flush (w_stop),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_key_code),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (queue_level)
  );

  // Step counter: runs while playing, holds while paused, clears when stopped
  always_ff @(posedge CLK_50M) begin
    if (RST || w_stop) begin
      r_cnt <= '0;
    end else if (w_playing) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  // Step pending flag: set on terminal count, consumed by WAIT_STEP; repeated
  // terminal counts simply coalesce into the already-set flag.
  always_ff @(posedge CLK_50M) begin
    if (RST || w_stop) begin
      r_step_pending <= 1'b0;
    end else if (w_playing) begin
      if (w_take_step) begin
        r_step_pending <= 1'b0;
      end else if (w_tc) begin
        r_step_pending <= 1'b1;
      end
    end
  end

  // Sticky overflow: a push into a full queue with no simultaneous pop
  always_ff @(posedge CLK_50M) begin
    if (RST || w_stop) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // FSM next-state and command selection; PAUSED leaves everything as is
  always_comb begin
    w_state_nx  = r_state;
    w_code_nx   = r_code;
    w_take_step = 1'b0;
    w_pop       = 1'b0;
    if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_code_nx  = c_CMD_GRAVITY;
    end else if (w_playing) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_WAIT_STEP;
        end
        ST_WAIT_STEP: begin
          if (w_step) begin
            w_take_step = 1'b1;
            w_pop       = !w_empty;
            w_code_nx   = w_empty ? c_CMD_GRAVITY : w_head;
            w_state_nx  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            w_code_nx  = c_CMD_GRAVITY;
            w_state_nx = ST_WAIT_STEP;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_code_nx  = c_CMD_GRAVITY;
        end
      endcase
    end
  end

  // FSM state and command register; reset wins over any handshake
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_code  <= c_CMD_GRAVITY;
    end else begin
      r_state <= w_state_nx;
      r_code  <= w_code_nx;
    end
  end

  // cmd_valid is masked while paused; the held code stays visible during the
  // pause and reads GRAVITY as soon as the game is stopped.
  assign cmd_valid = (r_state == ST_ISSUE) && w_playing;
  assign cmd_code  = ((r_state == ST_ISSUE) && !w_stop) ? r_code : c_CMD_GRAVITY;
  assign overflow  = r_overflow;

endmodule : key_cmd_scheduler
`default_nettype wire

// File: tb/tb_key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_cmd_scheduler
// Purpose  : Self-checking bench for key_cmd_scheduler (STEP_DIV=8, depth 4)
//            against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_cmd_scheduler;

  localparam int STEP_DIV = 8;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] gs  = 2'b00;
  logic       kl  = 1'b0;
  logic       kr  = 1'b0;
  logic       kd  = 1'b0;
  logic       rdy = 1'b0;
  logic       valid;
  logic [1:0] code;
  logic [2:0] level;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: queue of pending key codes plus game-step bookkeeping
  int m_q[$];
  int m_cnt    = 0;
  bit m_pend   = 0;
  bit m_active = 0;
  bit m_issue  = 0;
  int m_code   = 0;
  bit m_ovf    = 0;

  always #5 clk = ~clk;

  key_cmd_scheduler #(
    .STEP_DIV   (STEP_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK_50M         (clk),
    .RST             (rst),
    .game_state      (gs),
    .left_key_press  (kl),
    .right_key_press (kr),
    .down_key_press  (kd),
    .cmd_valid       (valid),
    .cmd_code        (code),
    .cmd_ready       (rdy),
    .queue_level     (level),
    .overflow        (ovf)
  );

  function automatic logic [6:0] exp_out();
    logic       v;
    logic [1:0] c;
    v = m_issue && (gs == 2'b01);
    c = (m_issue && gs != 2'b00 && gs != 2'b11) ? 2'(m_code) : 2'b00;
    return {v, c, 3'(m_q.size()), m_ovf};
  endfunction

  // One clock: advance the model with the inputs present at the edge,
  // then move away from the edge and drop the single-cycle key pulses.
  task automatic tick();
    bit tc;
    int k;
    @(posedge clk);
    if (rst || gs == 2'b00 || gs == 2'b11) begin
      m_q.delete();
      m_cnt = 0; m_pend = 0; m_active = 0; m_issue = 0; m_code = 0; m_ovf = 0;
    end else if (gs == 2'b01) begin
      tc    = (m_cnt == STEP_DIV - 1);
      m_cnt = tc ? 0 : m_cnt + 1;
      if (!m_active) begin
        m_active = 1;
        if (tc) m_pend = 1;
      end else if (m_issue) begin
        if (rdy) begin m_issue = 0; m_code = 0; end
        if (tc) m_pend = 1;
      end else if (m_pend || tc) begin
        m_pend  = 0;
        m_issue = 1;
        m_code  = (m_q.size() > 0) ? m_q.pop_front() : 0;
      end
      k = kd ? 3 : kl ? 1 : kr ? 2 : -1;
      if (k >= 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(k);
        else m_ovf = 1;
      end
    end
    #1;
    kl = 0; kr = 0; kd = 0;
  endtask

  task automatic do_reset();
    rst = 1; gs = 2'b00; rdy = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; gs = 2'b01; rdy = 1; kl = 1; kd = 1;
    tick();
    rst = 0; gs = 2'b00;
    #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (code !== 2'b00) $display("FAIL reset_code: got %b want 00", code); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_overflow: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_gravity();
    int pulses = 0;
    bit prev = 0, b2b = 0;
    do_reset();
    gs = 2'b01; rdy = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL gravity_cycle%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
      if (valid && prev) b2b = 1;
      if (valid) pulses++;
      prev = valid;
    end
    n_checks++; if (pulses !== 5) $display("FAIL gravity_count: got %0d want 5", pulses); else n_pass++;
    n_checks++; if (b2b !== 1'b0) $display("FAIL gravity_pulse_width: got wide pulse want 1-cycle"); else n_pass++;
  endtask

  task automatic test_queue_order();
    int codes[$];
    int lvls[$];
    do_reset();
    gs = 2'b01; rdy = 1;
    kl = 1; tick();
    kr = 1; tick();
    n_checks++; if (level !== 3'd2) $display("FAIL order_level2: got %0d want 2", level); else n_pass++;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL order_cycle%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
      if (valid) begin codes.push_back(int'(code)); lvls.push_back(int'(level)); end
    end
    n_checks++;
    if (codes.size() < 2 || codes[0] != 1 || codes[1] != 2 || lvls[0] != 1 || lvls[1] != 0)
      $display("FAIL order_codes: got codes %p levels %p want codes 1,2 levels 1,0", codes, lvls);
    else n_pass++;
  endtask

  task automatic test_priority();
    int first = -1;
    do_reset();
    gs = 2'b01; rdy = 1;
    kl = 1; kr = 1; kd = 1;
    tick();
    n_checks++; if (level !== 3'd1) $display("FAIL prio_level: got %0d want 1", level); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL prio_overflow: got %b want 0", ovf); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid && first < 0) first = int'(code);
    end
    n_checks++; if (first !== 3) $display("FAIL prio_code: got %0d want 3", first); else n_pass++;
  endtask

  task automatic test_overflow();
    int pat[5] = '{1, 2, 3, 1, 2};
    int codes[$];
    do_reset();
    gs = 2'b01; rdy = 0;
    for (int i = 0; i < 5; i++) begin
      kl = (pat[i] == 1); kr = (pat[i] == 2); kd = (pat[i] == 3);
      tick();
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL ovf_cycle%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
    end
    n_checks++; if (level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", level); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
    rdy = 1;
    for (int i = 0; i < 50; i++) begin
      if (valid && rdy) codes.push_back(int'(code));
      tick();
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL ovf_drain%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
    end
    n_checks++;
    if (codes.size() < 5 || codes[0] != 1 || codes[1] != 2 || codes[2] != 3 || codes[3] != 1 || codes[4] != 0)
      $display("FAIL ovf_drain_order: got %p want 1,2,3,1 then 0", codes);
    else n_pass++;
  endtask

  task automatic test_pause();
    logic [1:0] held;
    bit seen = 0;
    int k = 0;
    do_reset();
    gs = 2'b01; rdy = 0;
    kl = 1;
    tick();
    while (!valid && k < 20) begin tick(); k++; end
    n_checks++; if (valid !== 1'b1) $display("FAIL pause_wait_valid: got %b want 1 within 20 cycles", valid); else n_pass++;
    held = code;
    n_checks++; if (held !== 2'b01) $display("FAIL pause_code_before: got %b want 01", held); else n_pass++;
    tick(); tick();
    gs = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) seen = 1;
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL pause_cycle%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL pause_valid_masked: got valid=1 want 0"); else n_pass++;
    gs = 2'b01;
    #1;
    n_checks++;
    if ({valid, code} !== {1'b1, held}) $display("FAIL pause_resume: got %b want %b", {valid, code}, {1'b1, held});
    else n_pass++;
    rdy = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL resume_cycle%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    int k = 0;
    bit seen = 0;
    do_reset();
    gs = 2'b01; rdy = 0;
    kl = 1; tick();
    kr = 1; tick();
    kd = 1; tick();
    while (!valid && k < 20) begin tick(); k++; end
    n_checks++; if (valid !== 1'b1) $display("FAIL flush_wait_valid: got %b want 1", valid); else n_pass++;
    n_checks++; if (level !== 3'd2) $display("FAIL flush_level_before: got %0d want 2", level); else n_pass++;
    gs = 2'b11;
    tick();
    n_checks++;
    if ({valid, code, level, ovf} !== 7'b0) $display("FAIL flush_over: got %b want 0000000", {valid, code, level, ovf});
    else n_pass++;
    gs = 2'b01;
    kd = 1;
    k = 0;
    tick();
    while (!valid && k < 20) begin tick(); k++; end
    n_checks++; if (valid !== 1'b1) $display("FAIL flush_wait_valid2: got %b want 1", valid); else n_pass++;
    rdy = 1; rst = 1; kl = 1;
    tick();
    rst = 0;
    n_checks++;
    if ({valid, code, level, ovf} !== 7'b0) $display("FAIL flush_rst: got %b want 0000000", {valid, code, level, ovf});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_delivery: got valid after reset want none"); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    gs = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) gs = ($urandom_range(9) < 7) ? 2'b01 : 2'($urandom_range(3));
      kl  = ($urandom_range(3) == 0);
      kr  = ($urandom_range(3) == 0);
      kd  = ($urandom_range(5) == 0);
      rdy = ($urandom_range(2) != 0);
      rst = ($urandom_range(299) == 0);
      tick();
      rst = 0;
      n_checks++;
      if ({valid, code, level, ovf} !== exp_out())
        $display("FAIL random_cycle%0d: got %b want %b", i, {valid, code, level, ovf}, exp_out());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_queue_order();
    test_priority();
    test_overflow();
    test_pause();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_key_cmd_scheduler
`default_nettype wire
